// File: rtl/cpu_pkg.sv
// Shared constants and types for the multi-cycle LEGv8 core: FSM states, opcodes,
// ALU operation encodings and instruction classes.
package cpu_pkg;

  localparam logic [2:0] S_FETCH   = 3'd0;
  localparam logic [2:0] S_DECODE  = 3'd1;
  localparam logic [2:0] S_EXECUTE = 3'd2;
  localparam logic [2:0] S_MEM     = 3'd3;
  localparam logic [2:0] S_WB      = 3'd4;
  localparam logic [2:0] S_HALT    = 3'd5;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  // CBZ and B are matched on their fixed prefix only; the rest is immediate.
  localparam logic [7:0]  OP_CBZ  = 8'b10110100;
  localparam logic [5:0]  OP_B    = 6'b000101;

  localparam logic [4:0] XZR = 5'd31;

  typedef enum logic [1:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_ORR
  } alu_op_t;

  typedef enum logic [2:0] {
    IC_RTYPE,
    IC_LDUR,
    IC_STUR,
    IC_CBZ,
    IC_B,
    IC_ILLEGAL
  } iclass_t;

endpackage

// File: rtl/cpu_if.sv
// Instruction and data memory request/acknowledge bus between the core (master)
// and the memory system (slave).
interface cpu_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 64
);

  logic                  imem_req;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic                  imem_ack;
  logic [31:0]           imem_rdata;

  logic                  dmem_req;
  logic                  dmem_we;
  logic [ADDR_WIDTH-1:0] dmem_addr;
  logic [DATA_WIDTH-1:0] dmem_wdata;
  logic                  dmem_ack;
  logic [DATA_WIDTH-1:0] dmem_rdata;

  modport master (
    output imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  imem_ack, imem_rdata, dmem_ack, dmem_rdata
  );

  modport slave (
    input  imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output imem_ack, imem_rdata, dmem_ack, dmem_rdata
  );

endinterface

// File: rtl/cpu_decoder.sv
// Combinational LEGv8 decoder: instruction word to class, ALU op, register
// indices and sign-extended immediate.
module cpu_decoder
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH = 64
) (
  input  logic [31:0]                  i_ir,
  output iclass_t                      o_class,
  output alu_op_t                      o_alu_op,
  output logic [4:0]                   o_rn,
  output logic [4:0]                   o_rb,
  output logic [4:0]                   o_rd,
  output logic signed [DATA_WIDTH-1:0] o_imm,
  output logic                         o_illegal
);

  always_comb begin
    o_class  = IC_ILLEGAL;
    o_alu_op = ALU_ADD;
    o_imm    = '0;
    if (i_ir[31:21] == OP_ADD) begin
      o_class = IC_RTYPE;
    end else if (i_ir[31:21] == OP_SUB) begin
      o_class  = IC_RTYPE;
      o_alu_op = ALU_SUB;
    end else if (i_ir[31:21] == OP_AND) begin
      o_class  = IC_RTYPE;
      o_alu_op = ALU_AND;
    end else if (i_ir[31:21] == OP_ORR) begin
      o_class  = IC_RTYPE;
      o_alu_op = ALU_ORR;
    end else if (i_ir[31:21] == OP_LDUR) begin
      o_class = IC_LDUR;
      o_imm   = {{(DATA_WIDTH-9){i_ir[20]}}, i_ir[20:12]};
    end else if (i_ir[31:21] == OP_STUR) begin
      o_class = IC_STUR;
      o_imm   = {{(DATA_WIDTH-9){i_ir[20]}}, i_ir[20:12]};
    end else if (i_ir[31:24] == OP_CBZ) begin
      o_class = IC_CBZ;
      o_imm   = {{(DATA_WIDTH-19){i_ir[23]}}, i_ir[23:5]};
    end else if (i_ir[31:26] == OP_B) begin
      o_class = IC_B;
      o_imm   = {{(DATA_WIDTH-26){i_ir[25]}}, i_ir[25:0]};
    end
  end

  // STUR and CBZ carry their second source operand in the Rt slot.
  assign o_rb      = (o_class == IC_STUR || o_class == IC_CBZ) ? i_ir[4:0] : i_ir[20:16];
  assign o_rn      = i_ir[9:5];
  assign o_rd      = i_ir[4:0];
  assign o_illegal = (o_class == IC_ILLEGAL);

endmodule

// File: rtl/multicycle_cpu.sv
// Multi-cycle LEGv8 core: FETCH/DECODE/EXECUTE/MEM/WB sequencer with both memories
// behind req/ack handshakes, so any memory latency is tolerated.
module multicycle_cpu
  import cpu_pkg::*;
#(
  parameter int                    DATA_WIDTH = 64,
  parameter int                    ADDR_WIDTH = 64,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  cpu_if.master                 bus,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  retire,
  output logic                  halted
);

  logic [2:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic                  r_imem_req;
  logic                  r_dmem_req;
  logic                  r_dmem_we;
  logic [ADDR_WIDTH-1:0] r_dmem_addr;
  logic [DATA_WIDTH-1:0] r_dmem_wdata;
  logic                  r_retire;
  logic                  r_halted;

  logic [31:0]           r_ir;
  logic [DATA_WIDTH-1:0] r_a;
  logic [DATA_WIDTH-1:0] r_b;
  logic [DATA_WIDTH-1:0] r_alu;
  logic [DATA_WIDTH-1:0] r_mdr;
  logic [DATA_WIDTH-1:0] r_regs [0:31];

  iclass_t                      w_class;
  alu_op_t                      w_alu_op;
  logic [4:0]                   w_rn;
  logic [4:0]                   w_rb;
  logic [4:0]                   w_rd;
  logic signed [DATA_WIDTH-1:0] w_imm;
  logic                         w_illegal;

  logic [DATA_WIDTH-1:0] w_rf_a;
  logic [DATA_WIDTH-1:0] w_rf_b;
  logic [DATA_WIDTH-1:0] w_alu;
  logic [DATA_WIDTH-1:0] w_ea;
  logic [DATA_WIDTH-1:0] w_wb_data;
  logic [ADDR_WIDTH-1:0] w_pc_next;
  logic [ADDR_WIDTH-1:0] w_br_off;
  logic [ADDR_WIDTH-1:0] w_pc_branch;
  logic                  w_fetch_done;
  logic                  w_mem_done;
  logic                  w_rf_we;

  cpu_decoder #(.DATA_WIDTH(DATA_WIDTH)) u_decoder (
    .i_ir      (r_ir),
    .o_class   (w_class),
    .o_alu_op  (w_alu_op),
    .o_rn      (w_rn),
    .o_rb      (w_rb),
    .o_rd      (w_rd),
    .o_imm     (w_imm),
    .o_illegal (w_illegal)
  );

  assign w_rf_a = (w_rn == XZR) ? '0 : r_regs[w_rn];
  assign w_rf_b = (w_rb == XZR) ? '0 : r_regs[w_rb];

  always_comb begin
    w_alu = r_a + r_b;
    case (w_alu_op)
      ALU_SUB: w_alu = r_a - r_b;
      ALU_AND: w_alu = r_a & r_b;
      ALU_ORR: w_alu = r_a | r_b;
      default: w_alu = r_a + r_b;
    endcase
  end

  assign w_ea         = r_a + $unsigned(w_imm);
  assign w_pc_next    = r_pc + ADDR_WIDTH'(4);
  assign w_br_off     = {w_imm[ADDR_WIDTH-3:0], 2'b00};
  assign w_pc_branch  = r_pc + w_br_off;
  // Handshakes complete only while our own request is up; stray acks are ignored.
  assign w_fetch_done = r_imem_req & bus.imem_ack;
  assign w_mem_done   = r_dmem_req & bus.dmem_ack;
  assign w_wb_data    = (w_class == IC_LDUR) ? r_mdr : r_alu;
  assign w_rf_we      = !reset && (r_state == S_WB) && (w_rd != XZR);

  always_ff @(posedge clock) begin
    if (w_rf_we) r_regs[w_rd] <= w_wb_data;
  end

  always_ff @(posedge clock) begin
    if (r_state == S_FETCH && w_fetch_done) r_ir <= bus.imem_rdata;
    if (r_state == S_DECODE) begin
      r_a <= w_rf_a;
      r_b <= w_rf_b;
    end
    if (r_state == S_EXECUTE) r_alu <= w_alu;
    if (r_state == S_MEM && w_mem_done) r_mdr <= bus.dmem_rdata;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= S_FETCH;
      r_pc         <= RESET_PC;
      r_imem_req   <= 1'b0;
      r_dmem_req   <= 1'b0;
      r_dmem_we    <= 1'b0;
      r_dmem_addr  <= '0;
      r_dmem_wdata <= '0;
      r_retire     <= 1'b0;
      r_halted     <= 1'b0;
    end else begin
      r_retire <= 1'b0;
      case (r_state)
        S_FETCH: begin
          // First cycle out of reset raises the request; later fetches enter with it set.
          if (w_fetch_done) begin
            r_imem_req <= 1'b0;
            r_state    <= S_DECODE;
          end else begin
            r_imem_req <= 1'b1;
          end
        end
        S_DECODE: r_state <= S_EXECUTE;
        S_EXECUTE: begin
          if (w_illegal) begin
            r_state  <= S_HALT;
            r_halted <= 1'b1;
          end else begin
            case (w_class)
              IC_LDUR, IC_STUR: begin
                r_dmem_req   <= 1'b1;
                r_dmem_we    <= (w_class == IC_STUR);
                r_dmem_addr  <= w_ea[ADDR_WIDTH-1:0];
                r_dmem_wdata <= r_b;
                r_state      <= S_MEM;
              end
              IC_CBZ: begin
                r_pc       <= (r_b == '0) ? w_pc_branch : w_pc_next;
                r_retire   <= 1'b1;
                r_imem_req <= 1'b1;
                r_state    <= S_FETCH;
              end
              IC_B: begin
                r_pc       <= w_pc_branch;
                r_retire   <= 1'b1;
                r_imem_req <= 1'b1;
                r_state    <= S_FETCH;
              end
              default: r_state <= S_WB;
            endcase
          end
        end
        S_MEM: begin
          if (w_mem_done) begin
            r_dmem_req <= 1'b0;
            if (r_dmem_we) begin
              r_pc       <= w_pc_next;
              r_retire   <= 1'b1;
              r_imem_req <= 1'b1;
              r_state    <= S_FETCH;
            end else begin
              r_state <= S_WB;
            end
          end
        end
        S_WB: begin
          r_pc       <= w_pc_next;
          r_retire   <= 1'b1;
          r_imem_req <= 1'b1;
          r_state    <= S_FETCH;
        end
        default: r_state <= S_HALT;
      endcase
    end
  end

  assign bus.imem_req   = r_imem_req;
  assign bus.imem_addr  = r_pc;
  assign bus.dmem_req   = r_dmem_req;
  assign bus.dmem_we    = r_dmem_we;
  assign bus.dmem_addr  = r_dmem_addr;
  assign bus.dmem_wdata = r_dmem_wdata;
  assign pc             = r_pc;
  assign retire         = r_retire;
  assign halted         = r_halted;

endmodule

// File: tb/tb_multicycle_cpu.sv
// Directed bench for multicycle_cpu: the bench plays both memories and walks a
// table of instructions, checking fetch address, cycle count, next pc and bus traffic.
module tb_multicycle_cpu;

  localparam int DW = 64;
  localparam int AW = 64;

  localparam logic [10:0] T_ADD  = 11'b10001011000;
  localparam logic [10:0] T_SUB  = 11'b11001011000;
  localparam logic [10:0] T_AND  = 11'b10001010000;
  localparam logic [10:0] T_ORR  = 11'b10101010000;
  localparam logic [10:0] T_LDUR = 11'b11111000010;
  localparam logic [10:0] T_STUR = 11'b11111000000;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] pc;
  logic          retire;
  logic          halted;

  cpu_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  multicycle_cpu #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RESET_PC('0)) dut (
    .clock  (clock),
    .reset  (reset),
    .bus    (bus),
    .pc     (pc),
    .retire (retire),
    .halted (halted)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] instr;
    logic [63:0] ldata;
    int          idly;
    int          ddly;
    logic [63:0] fpc;
    logic [63:0] npc;
    int          cyc;
    int          acc;    // 0 none, 1 load, 2 store
    logic [63:0] daddr;
    logic [63:0] wdata;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;
  vec_t vt[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(logic [10:0] op, int rm, int rn, int rd);
    return {op, 5'(rm), 6'd0, 5'(rn), 5'(rd)};
  endfunction
  function automatic logic [31:0] enc_d(logic [10:0] op, int imm, int rn, int rt);
    return {op, 9'(imm), 2'b00, 5'(rn), 5'(rt)};
  endfunction
  function automatic logic [31:0] enc_cb(int imm, int rt);
    return {8'b10110100, 19'(imm), 5'(rt)};
  endfunction
  function automatic logic [31:0] enc_b(int imm);
    return {6'b000101, 26'(imm)};
  endfunction

  function automatic vec_t mk(logic [31:0] instr, logic [63:0] ldata, int idly, int ddly,
                              logic [63:0] fpc, logic [63:0] npc, int cyc, int acc,
                              logic [63:0] daddr, logic [63:0] wdata);
    vec_t v;
    v.instr = instr; v.ldata = ldata; v.idly = idly; v.ddly = ddly;
    v.fpc = fpc; v.npc = npc; v.cyc = cyc; v.acc = acc;
    v.daddr = daddr; v.wdata = wdata;
    return v;
  endfunction

  // Serve one instruction from fetch request to retire (or halt), checking as it goes.
  task automatic run_vec(input int k, input vec_t v);
    int          c = 0;
    int          icnt = 0;
    int          dcnt = 0;
    bit          done = 0;
    bit          unstable = 0;
    bit          seen_d = 0;
    bit          d_we = 0;
    logic [63:0] d_addr = '0;
    logic [63:0] d_wd = '0;
    logic [63:0] f_addr;
    int          acc_act;
    chk($sformatf("v%0d imem_req", k), {63'd0, bus.imem_req}, 64'd1);
    chk($sformatf("v%0d fetch_pc", k), bus.imem_addr, v.fpc);
    f_addr = bus.imem_addr;
    while (!done && c < 80) begin
      if (bus.imem_req) begin
        icnt++;
        if (bus.imem_addr !== f_addr) unstable = 1;
      end else begin
        icnt = 0;
      end
      bus.imem_ack   = bus.imem_req && (icnt == v.idly + 1);
      bus.imem_rdata = v.instr;
      if (bus.dmem_req) begin
        dcnt++;
        if (dcnt == 1) begin
          seen_d = 1;
          d_we   = bus.dmem_we;
          d_addr = bus.dmem_addr;
          d_wd   = bus.dmem_wdata;
        end else if (bus.dmem_we !== d_we || bus.dmem_addr !== d_addr || bus.dmem_wdata !== d_wd) begin
          unstable = 1;
        end
      end else begin
        dcnt = 0;
      end
      bus.dmem_ack   = bus.dmem_req && (dcnt == v.ddly + 1);
      bus.dmem_rdata = v.ldata;
      @(posedge clock); #1;
      c++;
      if (retire || halted) done = 1;
    end
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
    chk($sformatf("v%0d completed", k), {63'd0, done}, 64'd1);
    chk($sformatf("v%0d cycles", k), 64'(c), 64'(v.cyc));
    chk($sformatf("v%0d next_pc", k), pc, v.npc);
    chk($sformatf("v%0d bus_stable", k), {63'd0, unstable}, 64'd0);
    acc_act = seen_d ? (d_we ? 2 : 1) : 0;
    chk($sformatf("v%0d dmem_kind", k), 64'(acc_act), 64'(v.acc));
    if (v.acc != 0) chk($sformatf("v%0d dmem_addr", k), d_addr, v.daddr);
    if (v.acc == 2) chk($sformatf("v%0d dmem_wdata", k), d_wd, v.wdata);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          icnt;
    int          w;
    bit          got;
    bit          any_ireq;
    bit          any_dreq;
    bit          any_ret;

    bus.imem_ack   = 1'b0;
    bus.imem_rdata = '0;
    bus.dmem_ack   = 1'b0;
    bus.dmem_rdata = '0;

    // X1=5 and X2=3 come in through loads; X0 is set to 0 the same way.
    vt.push_back(mk(enc_d(T_LDUR, 8, 31, 1),   64'd5, 1, 1,   0,   4, 7, 1, 64'd8, 0));
    vt.push_back(mk(enc_d(T_LDUR, 16, 31, 2),  64'd3, 1, 1,   4,   8, 7, 1, 64'd16, 0));
    vt.push_back(mk(enc_cb(-2, 31),            0,     1, 1,   8,   0, 4, 0, 0, 0));
    vt.push_back(mk(enc_r(T_ADD, 2, 1, 3),     0,     1, 1,   0,   4, 5, 0, 0, 0));
    vt.push_back(mk(enc_r(T_SUB, 2, 1, 4),     0,     1, 1,   4,   8, 5, 0, 0, 0));
    vt.push_back(mk(enc_d(T_LDUR, 0, 31, 0),   64'd0, 1, 1,   8,  12, 7, 1, 64'd0, 0));
    vt.push_back(mk(enc_d(T_STUR, 16, 0, 3),   0,     1, 5,  12,  16, 10, 2, 64'd16, 64'd8));
    vt.push_back(mk(enc_d(T_LDUR, 16, 0, 5),   64'd8, 1, 5,  16,  20, 11, 1, 64'd16, 0));
    vt.push_back(mk(enc_d(T_STUR, 24, 0, 5),   0,     1, 1,  20,  24, 6, 2, 64'd24, 64'd8));
    vt.push_back(mk(enc_d(T_STUR, 32, 0, 4),   0,     1, 1,  24,  28, 6, 2, 64'd32, 64'd2));
    vt.push_back(mk(enc_cb(3, 1),              0,     1, 1,  28,  32, 4, 0, 0, 0));
    vt.push_back(mk(enc_b(16),                 0,     1, 1,  32,  96, 4, 0, 0, 0));
    vt.push_back(mk(enc_r(T_AND, 2, 1, 7),     0,     3, 1,  96, 100, 7, 0, 0, 0));
    vt.push_back(mk(enc_r(T_ADD, 2, 1, 31),    0,     1, 1, 100, 104, 5, 0, 0, 0));
    vt.push_back(mk(enc_r(T_ORR, 31, 31, 6),   0,     1, 1, 104, 108, 5, 0, 0, 0));
    vt.push_back(mk(enc_d(T_STUR, 40, 0, 6),   0,     1, 1, 108, 112, 6, 2, 64'd40, 64'd0));
    vt.push_back(mk(enc_d(T_STUR, 48, 0, 7),   0,     1, 1, 112, 116, 6, 2, 64'd48, 64'd1));
    vt.push_back(mk(enc_r(T_SUB, 1, 2, 8),     0,     1, 1, 116, 120, 5, 0, 0, 0));
    vt.push_back(mk(enc_d(T_STUR, -8, 0, 8),   0,     1, 1, 120, 124, 6, 2,
                    64'hFFFF_FFFF_FFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFFE));
    vt.push_back(mk(enc_b(-31),                0,     1, 1, 124,   0, 4, 0, 0, 0));
    vt.push_back(mk(32'h0000_0000,             0,     1, 1,   0,   0, 4, 0, 0, 0));

    // Reset held for three cycles.
    repeat (3) @(posedge clock);
    #1;
    chk("rst imem_req", {63'd0, bus.imem_req}, 64'd0);
    chk("rst dmem_req", {63'd0, bus.dmem_req}, 64'd0);
    chk("rst dmem_we", {63'd0, bus.dmem_we}, 64'd0);
    chk("rst dmem_addr", bus.dmem_addr, 64'd0);
    chk("rst dmem_wdata", bus.dmem_wdata, 64'd0);
    chk("rst pc", pc, 64'd0);
    chk("rst retire", {63'd0, retire}, 64'd0);
    chk("rst halted", {63'd0, halted}, 64'd0);
    reset = 1'b0;
    @(posedge clock); #1;
    chk("post_rst imem_req", {63'd0, bus.imem_req}, 64'd1);
    chk("post_rst imem_addr", bus.imem_addr, 64'd0);
    chk("post_rst retire", {63'd0, retire}, 64'd0);
    chk("post_rst halted", {63'd0, halted}, 64'd0);

    for (int i = 0; i < vt.size(); i++) run_vec(i, vt[i]);

    // Halted core must stay silent even when acks are thrown at it.
    chk("halt halted", {63'd0, halted}, 64'd1);
    any_ireq = 0; any_dreq = 0; any_ret = 0;
    for (int i = 0; i < 8; i++) begin
      bus.imem_ack = i[0];
      bus.dmem_ack = ~i[0];
      @(posedge clock); #1;
      if (bus.imem_req) any_ireq = 1;
      if (bus.dmem_req) any_dreq = 1;
      if (retire) any_ret = 1;
    end
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
    chk("halt no_imem_req", {63'd0, any_ireq}, 64'd0);
    chk("halt no_dmem_req", {63'd0, any_dreq}, 64'd0);
    chk("halt no_retire", {63'd0, any_ret}, 64'd0);
    chk("halt still_halted", {63'd0, halted}, 64'd1);
    chk("halt pc_held", pc, 64'd0);

    // Leave HALT via reset, then abandon a load mid-wait with another reset.
    reset = 1'b1;
    @(posedge clock); #1;
    chk("rst_halt halted", {63'd0, halted}, 64'd0);
    reset = 1'b0;
    @(posedge clock); #1;
    icnt = 0; w = 0; got = 0;
    bus.imem_rdata = enc_d(T_LDUR, 8, 31, 1);
    while (!got && w < 30) begin
      if (bus.imem_req) icnt++;
      else icnt = 0;
      bus.imem_ack = bus.imem_req && (icnt == 2);
      @(posedge clock); #1;
      w++;
      if (bus.dmem_req) got = 1;
    end
    bus.imem_ack = 1'b0;
    chk("rst_mid dmem_req_seen", {63'd0, got}, 64'd1);
    repeat (2) @(posedge clock);
    #1;
    chk("rst_mid dmem_req_held", {63'd0, bus.dmem_req}, 64'd1);
    chk("rst_mid dmem_addr", bus.dmem_addr, 64'd8);
    reset = 1'b1;
    @(posedge clock); #1;
    chk("rst_mid dmem_req", {63'd0, bus.dmem_req}, 64'd0);
    chk("rst_mid pc", pc, 64'd0);
    chk("rst_mid imem_req", {63'd0, bus.imem_req}, 64'd0);
    chk("rst_mid dmem_addr_clr", bus.dmem_addr, 64'd0);
    reset = 1'b0;
    @(posedge clock); #1;
    chk("rst_mid refetch_req", {63'd0, bus.imem_req}, 64'd1);
    chk("rst_mid refetch_addr", bus.imem_addr, 64'd0);
    chk("rst_mid no_retire", {63'd0, retire}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
